// File: rtl/bpfcpu_sequencer.sv
// Per-packet run controller for a pipelined BPF CPU core: releases the core on a
// packet, waits for accept/reject or watchdog expiry, then holds the verdict.
module bpfcpu_sequencer #(
   parameter int PLEN_WIDTH    = 10,
   parameter int TIMEOUT_WIDTH = 16,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pkt_valid,
   input  logic [PLEN_WIDTH-1:0]    pkt_len,
   output logic                     pkt_ready,
   output logic                     cpu_rst,
   output logic                     cpu_mem_ready,
   output logic [PLEN_WIDTH-1:0]    cpu_packet_len,
   input  logic                     cpu_acc,
   input  logic                     cpu_rej,
   input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
   output logic                     verdict_valid,
   output logic                     verdict_accept,
   output logic                     verdict_timeout,
   input  logic                     verdict_ready,
   output logic                     busy,
   output logic [COUNT_WIDTH-1:0]   acc_count,
   output logic [COUNT_WIDTH-1:0]   rej_count,
   output logic [COUNT_WIDTH-1:0]   to_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_VERDICT} state_t;

   state_t                   state, state_next;
   logic [TIMEOUT_WIDTH-1:0] timer, limit;
   logic                     pkt_fire;
   logic                     end_run, end_accept, end_timeout;

   assign pkt_fire = pkt_valid && pkt_ready;

   // Core reset must assert in the very cycle rst rises, so this path stays combinational.
   assign cpu_rst = rst | (state != S_RUN);

   always_comb begin
      state_next  = state;
      end_run     = 1'b0;
      end_accept  = 1'b0;
      end_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (pkt_fire) state_next = S_RUN;
         end
         S_RUN: begin
            // Core verdicts outrank the watchdog; accept outranks reject.
            if (cpu_acc) begin
               end_run    = 1'b1;
               end_accept = 1'b1;
            end else if (cpu_rej) begin
               end_run = 1'b1;
            end else if ((limit != '0) && (timer == limit - TIMEOUT_WIDTH'(1))) begin
               end_run     = 1'b1;
               end_timeout = 1'b1;
            end
            if (end_run) state_next = S_VERDICT;
         end
         S_VERDICT: begin
            if (verdict_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         timer           <= '0;
         limit           <= '0;
         cpu_packet_len  <= '0;
         acc_count       <= '0;
         rej_count       <= '0;
         to_count        <= '0;
         pkt_ready       <= 1'b1;
         busy            <= 1'b0;
         cpu_mem_ready   <= 1'b0;
         verdict_valid   <= 1'b0;
         verdict_accept  <= 1'b0;
         verdict_timeout <= 1'b0;
      end else begin
         state         <= state_next;
         pkt_ready     <= (state_next == S_IDLE);
         busy          <= (state_next != S_IDLE);
         cpu_mem_ready <= (state_next == S_RUN);
         verdict_valid <= (state_next == S_VERDICT);

         if (state == S_IDLE && pkt_fire) begin
            cpu_packet_len <= pkt_len;
            limit          <= timeout_cycles;
            timer          <= '0;
         end else if (state == S_RUN) begin
            timer <= timer + TIMEOUT_WIDTH'(1);
         end

         if (end_run) begin
            verdict_accept  <= end_accept;
            verdict_timeout <= end_timeout;
            // Exactly one counter moves per verdict, saturating at all-ones.
            if (end_accept) begin
               if (acc_count != '1) acc_count <= acc_count + COUNT_WIDTH'(1);
            end else if (end_timeout) begin
               if (to_count != '1) to_count <= to_count + COUNT_WIDTH'(1);
            end else begin
               if (rej_count != '1) rej_count <= rej_count + COUNT_WIDTH'(1);
            end
         end else if (state_next != S_VERDICT) begin
            verdict_accept  <= 1'b0;
            verdict_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bpfcpu_sequencer.sv
// Directed and randomized bench for bpfcpu_sequencer; outcomes predicted from
// run-length arithmetic (first core pulse vs watchdog limit).
module tb_bpfcpu_sequencer;

   localparam int PW   = 10;
   localparam int TW   = 16;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          pkt_valid;
   logic [PW-1:0] pkt_len;
   logic          pkt_ready;
   logic          cpu_rst;
   logic          cpu_mem_ready;
   logic [PW-1:0] cpu_packet_len;
   logic          cpu_acc;
   logic          cpu_rej;
   logic [TW-1:0] timeout_cycles;
   logic          verdict_valid;
   logic          verdict_accept;
   logic          verdict_timeout;
   logic          verdict_ready;
   logic          busy;
   logic [CW-1:0] acc_count;
   logic [CW-1:0] rej_count;
   logic [CW-1:0] to_count;

   int tests    = 0;
   int failures = 0;
   int acc_m    = 0;
   int rej_m    = 0;
   int to_m     = 0;

   bpfcpu_sequencer #(.PLEN_WIDTH(PW), .TIMEOUT_WIDTH(TW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_ready(pkt_ready),
      .cpu_rst(cpu_rst), .cpu_mem_ready(cpu_mem_ready), .cpu_packet_len(cpu_packet_len),
      .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .timeout_cycles(timeout_cycles),
      .verdict_valid(verdict_valid), .verdict_accept(verdict_accept),
      .verdict_timeout(verdict_timeout), .verdict_ready(verdict_ready),
      .busy(busy), .acc_count(acc_count), .rej_count(rej_count), .to_count(to_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, ".acc_count"}, 32'(acc_count), 32'(acc_m));
      check({tag, ".rej_count"}, 32'(rej_count), 32'(rej_m));
      check({tag, ".to_count"},  32'(to_count),  32'(to_m));
   endtask

   // One packet from IDLE to IDLE. acc_at/rej_at are 1-based RUN cycles (0 = never).
   task automatic run_pkt(input int len, input int tmo, input int acc_at,
                          input int rej_at, input int hold);
      int core, exp_len, rc;
      bit exp_acc, exp_to;
      if (acc_at == 0)      core = rej_at;
      else if (rej_at == 0) core = acc_at;
      else                  core = (acc_at <= rej_at) ? acc_at : rej_at;
      if (tmo != 0 && (core == 0 || tmo < core)) begin
         exp_len = tmo; exp_acc = 1'b0; exp_to = 1'b1;
      end else begin
         exp_len = core; exp_acc = (acc_at == core); exp_to = 1'b0;
      end

      pkt_valid      = 1'b1;
      pkt_len        = PW'(len);
      timeout_cycles = TW'(tmo);
      tick();
      pkt_valid      = 1'b0;
      pkt_len        = PW'($urandom);
      timeout_cycles = TW'($urandom_range(1, 4));
      check("run.cpu_rst",        32'(cpu_rst), 0);
      check("run.cpu_mem_ready",  32'(cpu_mem_ready), 1);
      check("run.cpu_packet_len", 32'(cpu_packet_len), 32'(len));
      check("run.pkt_ready",      32'(pkt_ready), 0);

      rc = 0;
      while (cpu_rst === 1'b0 && rc < 300) begin
         rc++;
         cpu_acc = (rc == acc_at);
         cpu_rej = (rc == rej_at);
         tick();
      end
      cpu_acc = 1'b0;
      cpu_rej = 1'b0;
      check("run.length",          32'(rc), 32'(exp_len));
      check("verdict.valid",       32'(verdict_valid), 1);
      check("verdict.accept",      32'(verdict_accept), 32'(exp_acc));
      check("verdict.timeout",     32'(verdict_timeout), 32'(exp_to));
      check("verdict.cpu_rst",     32'(cpu_rst), 1);
      check("verdict.mem_ready",   32'(cpu_mem_ready), 0);
      check("verdict.busy",        32'(busy), 1);

      if (exp_acc)     acc_m = (acc_m < CMAX) ? acc_m + 1 : CMAX;
      else if (exp_to) to_m  = (to_m  < CMAX) ? to_m  + 1 : CMAX;
      else             rej_m = (rej_m < CMAX) ? rej_m + 1 : CMAX;
      check_counters("verdict");

      // Downstream stalls while a new packet and stray core pulses are offered.
      for (int i = 0; i < hold; i++) begin
         verdict_ready = 1'b0;
         pkt_valid     = 1'b1;
         cpu_acc       = 1'b1;
         tick();
         check("hold.valid",     32'(verdict_valid), 1);
         check("hold.accept",    32'(verdict_accept), 32'(exp_acc));
         check("hold.timeout",   32'(verdict_timeout), 32'(exp_to));
         check("hold.pkt_ready", 32'(pkt_ready), 0);
         check("hold.cpu_rst",   32'(cpu_rst), 1);
      end
      cpu_acc       = 1'b0;
      pkt_valid     = 1'b0;
      verdict_ready = 1'b1;
      tick();
      verdict_ready = 1'b0;
      check("idle.verdict_valid", 32'(verdict_valid), 0);
      check("idle.pkt_ready",     32'(pkt_ready), 1);
      check("idle.busy",          32'(busy), 0);
      check_counters("idle");
   endtask

   initial begin
      rst = 1'b1; pkt_valid = 1'b0; pkt_len = '0; cpu_acc = 1'b0; cpu_rej = 1'b0;
      timeout_cycles = '0; verdict_ready = 1'b0;
      tick();
      tick();
      check("reset.cpu_rst",        32'(cpu_rst), 1);
      check("reset.pkt_ready",      32'(pkt_ready), 1);
      check("reset.busy",           32'(busy), 0);
      check("reset.verdict_valid",  32'(verdict_valid), 0);
      check("reset.mem_ready",      32'(cpu_mem_ready), 0);
      check("reset.cpu_packet_len", 32'(cpu_packet_len), 0);
      rst = 1'b0;
      tick();
      check("post_reset.cpu_rst", 32'(cpu_rst), 1);
      check_counters("post_reset");

      // Reset pulsed on the 3rd RUN cycle.
      pkt_valid = 1'b1; pkt_len = PW'(33); timeout_cycles = '0;
      tick();
      pkt_valid = 1'b0;
      tick();
      tick();
      check("midrun.cpu_rst_before", 32'(cpu_rst), 0);
      rst = 1'b1;
      #1;
      check("midrun.cpu_rst_same_cycle", 32'(cpu_rst), 1);
      tick();
      rst = 1'b0;
      tick();
      check("midrun.pkt_ready",     32'(pkt_ready), 1);
      check("midrun.busy",          32'(busy), 0);
      check("midrun.verdict_valid", 32'(verdict_valid), 0);
      check_counters("midrun");

      run_pkt(60, 0, 5, 0, 0);    // accept on 5th RUN cycle
      run_pkt(17, 8, 0, 0, 0);    // watchdog after 8 cycles
      run_pkt(100, 0, 4, 4, 0);   // simultaneous accept and reject
      run_pkt(200, 3, 0, 3, 0);   // reject in the expiry cycle
      run_pkt(512, 0, 2, 0, 10);  // long stall with pkt_valid high
      run_pkt(1023, 1, 0, 0, 0);  // single-cycle watchdog
      run_pkt(5, 4, 0, 2, 1);

      for (int n = 0; n < 20; n++) begin
         int tmo, a, r;
         tmo = $urandom_range(0, 12);
         a   = $urandom_range(0, 15);
         r   = $urandom_range(0, 15);
         if (tmo == 0 && a == 0 && r == 0) a = 1;
         run_pkt($urandom_range(0, 1023), tmo, a, r, $urandom_range(0, 3));
      end

      // Drive accepts until the counter saturates, then two more.
      while (acc_m < CMAX) run_pkt(64, 0, 1, 0, 0);
      run_pkt(64, 0, 1, 0, 0);
      check("sat.acc_count_a", 32'(acc_count), 32'(CMAX));
      run_pkt(64, 0, 1, 0, 0);
      check("sat.acc_count_b", 32'(acc_count), 32'(CMAX));

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
